lif_neuron_array: RTL

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

---
 rtl/lif_pkg.sv | 27 ++
 rtl/lif_channel.sv | 82 ++++++++
 rtl/lif_neuron_array.sv | 75 +++++++
 3 files changed

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared defaults and arithmetic helpers for the LIF neuron array
//
// Purpose: parameter defaults for lif_neuron_array / lif_channel and the
// saturating adder used by every channel.
// Ports: none (package).
package lif_pkg;

  localparam int N_CH_DEF          = 4;
  localparam int IW_DEF            = 6;
  localparam int W_DEF             = 8;
  localparam int LEAK_SHIFT_DEF    = 1;
  localparam int THR_RESET_DEF     = 32;
  localparam int REFRACT_STEPS_DEF = 2;

  // Adds two unsigned operands with one guard bit and clamps the result to
  // the largest value representable in w bits (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] max_val;
    s       = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << w) - 33'd1;
    return (s > max_val) ? max_val[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/lif_channel.sv
// rtl/lif_channel.sv - one leaky integrate-and-fire neuron channel
//
// Purpose: integrates its input current with leak, fires when the saturated
// sum reaches the shared threshold. Optional refractory period when
// LIF_NEURON_ARRAY_REFRACTORY_EN is defined.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ena          - step strobe
//   current      - input current (IW bits, unsigned)
//   threshold    - shared firing threshold (W bits)
//   state        - registered membrane state
//   spike        - registered spike flag from the last step
//   spike_next   - spike value that the current step will register
module lif_channel
  import lif_pkg::*;
#(
  parameter int IW            = IW_DEF,
  parameter int W             = W_DEF,
  parameter int LEAK_SHIFT    = LEAK_SHIFT_DEF,
  parameter int REFRACT_STEPS = REFRACT_STEPS_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [IW-1:0] current,
  input  logic [W-1:0]  threshold,
  output logic [W-1:0]  state,
  output logic          spike,
  output logic          spike_next
);

  logic [W-1:0] leaked;
  logic [W-1:0] sum;
  logic         fire;

  assign leaked = state >> LEAK_SHIFT;
  assign sum    = W'(sat_add(32'(current), 32'(leaked), W));
  assign fire   = (sum >= threshold);

`ifdef LIF_NEURON_ARRAY_REFRACTORY_EN
  logic [3:0] refr_cnt;
  logic       blocked;

  assign blocked    = (refr_cnt != 4'd0);
  assign spike_next = fire & ~blocked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= '0;
      spike    <= 1'b0;
      refr_cnt <= 4'd0;
    end else if (ena) begin
      if (blocked) begin
        // Refractory: input is ignored and the membrane is clamped at rest.
        refr_cnt <= refr_cnt - 4'd1;
        state    <= '0;
        spike    <= 1'b0;
      end else if (fire) begin
        refr_cnt <= 4'(REFRACT_STEPS);
        state    <= '0;
        spike    <= 1'b1;
      end else begin
        state    <= sum;
        spike    <= 1'b0;
      end
    end
  end
`else
  assign spike_next = fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      spike <= 1'b0;
    end else if (ena) begin
      state <= fire ? '0 : sum;
      spike <= fire;
    end
  end
`endif

endmodule

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - array of independent LIF neurons with shared threshold
//
// Purpose: N_CH leaky integrate-and-fire channels stepped by ena, sharing one
// programmable threshold. Optional feature macro: LIF_NEURON_ARRAY_REFRACTORY_EN.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ena          - step strobe, one neuron time step per cycle high
//   in_current   - channel i current at [i*IW +: IW]
//   cfg_thr_we   - threshold write enable
//   cfg_thr      - new threshold value
//   threshold    - active threshold
//   state        - channel i membrane state at [i*W +: W]
//   spike        - per-channel spike flags from the last step
//   spike_any    - OR of spike, registered with it
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_CH          = N_CH_DEF,
  parameter int IW            = IW_DEF,
  parameter int W             = W_DEF,
  parameter int LEAK_SHIFT    = LEAK_SHIFT_DEF,
  parameter int THR_RESET     = THR_RESET_DEF,
  parameter int REFRACT_STEPS = REFRACT_STEPS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [N_CH*IW-1:0] in_current,
  input  logic              cfg_thr_we,
  input  logic [W-1:0]      cfg_thr,
  output logic [W-1:0]      threshold,
  output logic [N_CH*W-1:0] state,
  output logic [N_CH-1:0]   spike,
  output logic              spike_any
);

  logic [N_CH-1:0] spike_next;

  // A write in a step cycle lands at the edge, so that step still sees
  // the old threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold <= W'(THR_RESET);
    end else if (cfg_thr_we) begin
      threshold <= cfg_thr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_any <= 1'b0;
    end else if (ena) begin
      spike_any <= |spike_next;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    lif_channel #(
      .IW            (IW),
      .W             (W),
      .LEAK_SHIFT    (LEAK_SHIFT),
      .REFRACT_STEPS (REFRACT_STEPS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .current    (in_current[i*IW +: IW]),
      .threshold  (threshold),
      .state      (state[i*W +: W]),
      .spike      (spike[i]),
      .spike_next (spike_next[i])
    );
  end

endmodule
